// File: rtl/store_buffer_pkg.sv
// Shared types and defaults for the store buffer: one buffered store entry
// (word address, data, byte mask) and the default buffer depth.
package store_buffer_pkg;

  typedef struct packed {
    logic [29:0] waddr;
    logic [31:0] data;
    logic [3:0]  mask;
  } stb_entry_t;

  localparam int STB_DEPTH_DEFAULT = 4;

endpackage

// File: rtl/store_buffer_fifo.sv
// In-order entry storage for the store buffer. Exposes every slot and its
// valid bit so the parent can compare pending stores against a load.
module store_buffer_fifo
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = STB_DEPTH_DEFAULT,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    push_in,
  input  stb_entry_t              wr_entry_in,
  input  logic                    pop_in,
  output stb_entry_t              head_out,
  output stb_entry_t [DEPTH-1:0]  entries_out,
  output logic [DEPTH-1:0]        valid_out,
  output logic                    full_out,
  output logic                    empty_out
);

  localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];

  stb_entry_t [DEPTH-1:0] mem_reg;
  logic [PTR_W-1:0]       wr_ptr_reg;
  logic [PTR_W-1:0]       rd_ptr_reg;
  logic [PTR_W:0]         count_reg;
  logic                   push_ok;

  // Full is taken from the registered count, so a same-cycle pop never frees
  // a slot for the push.
  assign full_out  = (count_reg == FULL_CNT);
  assign empty_out = (count_reg == '0);
  assign push_ok   = push_in & ~full_out;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_in)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push_ok, pop_in})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (push_ok) mem_reg[wr_ptr_reg] <= wr_entry_in;
  end

  assign head_out    = mem_reg[rd_ptr_reg];
  assign entries_out = mem_reg;

  // A slot is live when its distance from the read pointer is below count.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_valid
      logic [PTR_W-1:0] offset;
      assign offset        = PTR_W'(gi) - rd_ptr_reg;
      assign valid_out[gi] = ({1'b0, offset} < count_reg);
    end
  endgenerate

endmodule

// File: rtl/store_buffer.sv
// Posted-write buffer between the store unit and the data-memory bus, with
// in-order drain and a load/store word-address hazard flag.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = STB_DEPTH_DEFAULT,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] dmaddr_in,
  input  logic [31:0] dmdata_in,
  input  logic [3:0]  dmwr_mask_in,
  input  logic        dmwr_req_in,
  output logic        stall_out,
  input  logic        ld_req_in,
  input  logic [31:0] ld_addr_in,
  output logic        ld_hazard_out,
  output logic        bus_valid_out,
  input  logic        bus_ready_in,
  output logic [31:0] bus_addr_out,
  output logic [31:0] bus_data_out,
  output logic [3:0]  bus_mask_out,
  output logic        empty_out
);

  stb_entry_t              wr_entry;
  stb_entry_t              head;
  stb_entry_t [DEPTH-1:0]  entries;
  logic [DEPTH-1:0]        valid;
  logic [DEPTH-1:0]        entry_match;
  logic                    full;
  logic                    empty;
  logic                    pop;
  logic                    push_match;
  logic                    unused_low_bits;

  assign unused_low_bits = ^{dmaddr_in[1:0], ld_addr_in[1:0], PTR_W[0]};

  assign wr_entry = '{waddr: dmaddr_in[31:2], data: dmdata_in, mask: dmwr_mask_in};
  assign pop      = ~empty & bus_ready_in;

  store_buffer_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .push_in     (dmwr_req_in),
    .wr_entry_in (wr_entry),
    .pop_in      (pop),
    .head_out    (head),
    .entries_out (entries),
    .valid_out   (valid),
    .full_out    (full),
    .empty_out   (empty)
  );

  assign stall_out     = full;
  assign empty_out     = empty;
  assign bus_valid_out = ~empty;
  assign bus_addr_out  = empty ? 32'h0 : {head.waddr, 2'b00};
  assign bus_data_out  = empty ? 32'h0 : head.data;
  assign bus_mask_out  = empty ? 4'h0  : head.mask;

  // Word-granular compare; the head being popped this cycle still counts.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
      assign entry_match[gi] = valid[gi] && (entries[gi].waddr == ld_addr_in[31:2]);
    end
  endgenerate

  assign push_match    = dmwr_req_in && (dmaddr_in[31:2] == ld_addr_in[31:2]);
  assign ld_hazard_out = ~rst_in & ld_req_in & (|entry_match | push_match);

endmodule
